mult_sequencer: RTL and testbench

//  Multi-cycle signed 32x32->64 multiplier sequencer for the EX stage.

---
 rtl/mult_sequencer.sv | 135 +++++++++++++
 tb/tb_mult_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Multi-cycle signed multiplier for the EX stage: radix-2 shift-add over DATA_W
// iterations on operand magnitudes, sign applied when the product is committed.
module mult_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_hi,
    output logic [DATA_W-1:0] result_lo
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                neg_q, neg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   res_hi_q, res_hi_d;
    logic [DATA_W-1:0]   res_lo_q, res_lo_d;
    logic                done_q, busy_q;

    logic                accept_c;
    logic [DATA_W-1:0]   abs_a_c, abs_b_c;
    logic [DATA_W:0]     sum_c;
    logic [DATA_W-1:0]   it_hi_c, it_lo_c;
    logic [PROD_W-1:0]   prod_c, signed_c;

    assign accept_c = start & ~flush;

    // Magnitudes treated as unsigned, so the most-negative operand maps to 2^(DATA_W-1).
    assign abs_a_c = op_a[DATA_W-1] ? (~op_a + DATA_W'(1)) : op_a;
    assign abs_b_c = op_b[DATA_W-1] ? (~op_b + DATA_W'(1)) : op_b;

    // One shift-add step; the multiplier register doubles as the low product half.
    always_comb begin
        sum_c    = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : (DATA_W + 1)'(0));
        it_hi_c  = sum_c[DATA_W:1];
        it_lo_c  = {sum_c[0], mplier_q[DATA_W-1:1]};
        prod_c   = {it_hi_c, it_lo_c};
        signed_c = neg_q ? (~prod_c + PROD_W'(1)) : prod_c;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    state_d  = S_RUN;
                    mcand_d  = abs_a_c;
                    mplier_d = abs_b_c;
                    neg_d    = op_a[DATA_W-1] ^ op_b[DATA_W-1];
                    acc_hi_d = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = it_hi_c;
                    mplier_d = it_lo_c;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // Final iteration commits the signed product on the edge into DONE.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d  = S_DONE;
                        res_hi_d = signed_c[PROD_W-1:DATA_W];
                        res_lo_d = signed_c[DATA_W-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= (state_d == S_DONE);
            busy_q   <= (state_d == S_RUN);
        end
    end

    // Combinational so EX holds its operands in the request cycle.
    assign stall = (accept_c & ((state_q == S_IDLE) | (state_q == S_DONE)))
                 | (state_q == S_RUN);

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed products, flush, back-to-back and async reset.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start, flush;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result_hi, result_lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb[$];

    mult_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected product and its cycle.
    always @(negedge clk) begin
        if (arst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_hi", 64'(result_hi), 64'(e.hi));
                chk("result_lo", 64'(result_lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Drive a request for one cycle; if wait_edge is 0 it is issued in the current cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input bit push, input bit wait_edge);
        exp_t e;
        if (wait_edge) @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        if (push) begin
            e.hi = hi;
            e.lo = lo;
            e.at = cyc + 33;
            sb.push_back(e);
        end
        #1;
        chk("stall_req", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Wait for done, checking stall/busy through RUN; returns at the done negedge.
    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            if (stall !== 1'b1 || busy !== 1'b1) chk("stall_busy_run", {stall, busy}, 2'b11);
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("stall_done", 64'(stall), 64'd0);
        chk("busy_done", 64'(busy), 64'd0);
    endtask

    initial begin
        arst_n = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        #1;
        chk("rst_outputs", {stall, busy, done}, 3'b000);
        chk("rst_results", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Basic products
        issue(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1, 1);
        wait_done();
        issue(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 1);
        wait_done();
        issue(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1, 1);
        wait_done();
        issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1, 1);
        wait_done();
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1, 1);
        wait_done();

        // Idle flush with start: no transition, no stall
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_a = 32'd5; op_b = 32'd5;
        #1;
        chk("stall_flush_idle", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("busy_flush_idle", 64'(busy), 64'd0);

        // Flush mid-run at cycle 10
        issue(32'd6, 32'd7, 32'd0, 32'd0, 0, 1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("stall_flush_run", 64'(stall), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("idle_after_flush", {stall, busy, done}, 3'b000);
        repeat (35) @(negedge clk);
        chk("results_held", {result_hi, result_lo}, 64'hFFFF_FFFF_8000_0001);

        // Back-to-back: second request presented in the DONE cycle
        issue(32'd2, 32'd2, 32'd0, 32'd4, 1, 1);
        wait_done();
        issue(32'd4, 32'd4, 32'd0, 32'd16, 1, 0);
        wait_done();

        // Async reset mid-run at cycle 15
        issue(32'd5, 32'd5, 32'd0, 32'd0, 0, 1);
        repeat (14) @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {stall, busy, done}, 3'b000);
        chk("rst_mid_results", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        issue(32'd9, 32'd9, 32'd0, 32'h0000_0051, 1, 1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
